// File: rtl/jpeg_dec_pkg.sv
// rtl/jpeg_dec_pkg.sv - shared token layout for the JPEG decoder coefficient path
//
// Purpose: one 18-bit token format used between the Huffman/RLE decoder,
//          the burst FIFO and the reorder stage.
// Layout : COEF[17:6], DC[5], LST[4], ZR[3:0]
package jpeg_dec_pkg;

  localparam int TOK_W = 18;

  typedef struct packed {
    logic [11:0] coef;
    logic        dc;
    logic        lst;
    logic [3:0]  zr;
  } tok_t;

endpackage

// File: rtl/sfifo_ff.sv
// rtl/sfifo_ff.sv - synchronous first-word-fall-through FIFO
//
// Purpose: flop-based storage of 2**AW words; rd_data_o always shows the head.
// Ports  : clk_i, rst_ni (async active-low), clr_i (sync clear),
//          wr_en_i/wr_data_i (ignored when full), rd_en_i (ignored when empty),
//          rd_data_o (head word), count_o (stored words), full_o, empty_o.
module sfifo_ff #(
  parameter int DW = 18,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_ok, rd_ok;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign wr_ok     = wr_en_i & ~full_o;
  assign rd_ok     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_dec_burst_fifo.sv
// rtl/jpeg_dec_burst_fifo.sv - block-granular coefficient buffer ahead of the reorder stage
//
// Purpose: buffers decoded tokens; with BURST=1 a block is released only once its
//          LST token is stored, so the reorder stage sees gap-free bursts.
// Ports  : iCLK, iRSTN (async active-low), iINIT (sync clear per image),
//          iPI_EN/iPI/iPI_DC/iPI_LST/iPI_ZR (input token, no ready),
//          oBRST_AFULL (registered almost-full to producer),
//          oPO_EN/oPO/oPO_DC/oPO_LST/oPO_ZR (registered output token),
//          iREORD_AFULL (downstream almost-full), oDEPTH (stored count),
//          oOVF (sticky overflow: token dropped while full).
module jpeg_dec_burst_fifo
  import jpeg_dec_pkg::*;
#(
  parameter int AW        = 8,
  parameter int AF_MARGIN = 4,
  parameter int BURST     = 1
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  input  logic        iINIT,
  input  logic        iPI_EN,
  input  logic [11:0] iPI,
  input  logic        iPI_DC,
  input  logic        iPI_LST,
  input  logic [3:0]  iPI_ZR,
  output logic        oBRST_AFULL,
  output logic        oPO_EN,
  output logic [11:0] oPO,
  output logic        oPO_DC,
  output logic        oPO_LST,
  output logic [3:0]  oPO_ZR,
  input  logic        iREORD_AFULL,
  output logic [AW:0] oDEPTH,
  output logic        oOVF
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] AF_THR   = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic        BURST_EN = (BURST != 0);

  tok_t        wr_tok, head, po_q;
  logic [AW:0] cnt, depth_d;
  logic [AW:0] blk_cnt_q, blk_cnt_d;
  logic        full, empty, wr_en, rd_req, lst_wr, lst_rd;
  logic        force_rel_q, force_rel_d;
  logic        afull_q, afull_d, ovf_q, ovf_d, po_en_q;

  assign wr_tok = '{coef: iPI, dc: iPI_DC, lst: iPI_LST, zr: iPI_ZR};
  assign wr_en  = iPI_EN & ~full & ~iINIT;
  // force_rel lets an oversize block (no LST while full) drain instead of deadlocking.
  assign rd_req = ~empty & ~iREORD_AFULL & ~iINIT &
                  (~BURST_EN | (blk_cnt_q != '0) | force_rel_q);
  assign lst_wr = wr_en & iPI_LST;
  assign lst_rd = rd_req & head.lst;

  sfifo_ff #(.DW(TOK_W), .AW(AW)) u_store (
    .clk_i    (iCLK),
    .rst_ni   (iRSTN),
    .clr_i    (iINIT),
    .wr_en_i  (wr_en),
    .wr_data_i(wr_tok),
    .rd_en_i  (rd_req),
    .rd_data_o(head),
    .count_o  (cnt),
    .full_o   (full),
    .empty_o  (empty)
  );

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    case ({lst_wr, lst_rd})
      2'b10:   blk_cnt_d = blk_cnt_q + CNT_ONE;
      2'b01:   blk_cnt_d = blk_cnt_q - CNT_ONE;
      default: blk_cnt_d = blk_cnt_q;
    endcase

    force_rel_d = force_rel_q;
    if (lst_rd)                         force_rel_d = 1'b0;
    else if (full && blk_cnt_q == '0)   force_rel_d = 1'b1;

    ovf_d = ovf_q | (iPI_EN & full);

    // Almost-full is taken from the next depth so it lines up with oDEPTH.
    depth_d = cnt;
    case ({wr_en, rd_req})
      2'b10:   depth_d = cnt + CNT_ONE;
      2'b01:   depth_d = cnt - CNT_ONE;
      default: depth_d = cnt;
    endcase
    afull_d = (depth_d >= AF_THR);
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      blk_cnt_q   <= '0;
      force_rel_q <= 1'b0;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
      po_en_q     <= 1'b0;
      po_q        <= '0;
    end else if (iINIT) begin
      blk_cnt_q   <= '0;
      force_rel_q <= 1'b0;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
      po_en_q     <= 1'b0;
      po_q        <= '0;
    end else begin
      blk_cnt_q   <= blk_cnt_d;
      force_rel_q <= force_rel_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
      po_en_q     <= rd_req;
      if (rd_req) po_q <= head;
    end
  end

  assign oBRST_AFULL = afull_q;
  assign oPO_EN      = po_en_q;
  assign oPO         = po_q.coef;
  assign oPO_DC      = po_q.dc;
  assign oPO_LST     = po_q.lst;
  assign oPO_ZR      = po_q.zr;
  assign oDEPTH      = cnt;
  assign oOVF        = ovf_q;

endmodule
